multicycle_control: RTL and testbench

// - Multi-cycle sequencer for the RV32I datapath: drives PCSrc/RegWrite/ALUControl/ALUSrcA/ALUSrcB/MemWrite/

---
 rtl/mctrl_pkg.sv | 84 ++++++++
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/mctrl_alu_decoder.sv | 46 ++++
 rtl/multicycle_control.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mctrl_pkg.sv
// ----------------------------------------------------------------------------
// mctrl_pkg
// Shared definitions for the multi-cycle RV32I control unit:
//   - state_t and the FSM state encodings (plain localparams, legacy-compatible)
//   - RV32I major opcodes
//   - ALUControl, ImmSrc, ResultSrc and PCSrc encodings
//   - small helpers: immediate-format selection and opcode legality
// ----------------------------------------------------------------------------
package mctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_EXEC     = 4'd2;
    localparam state_t S_UPPER    = 4'd3;
    localparam state_t S_WB       = 4'd4;
    localparam state_t S_MEM_ADDR = 4'd5;
    localparam state_t S_MEM_RD   = 4'd6;
    localparam state_t S_MEM_WR   = 4'd7;
    localparam state_t S_BRANCH   = 4'd8;
    localparam state_t S_JUMP     = 4'd9;
    localparam state_t S_NOP      = 4'd10;
    localparam state_t S_HALTED   = 4'd11;
    localparam state_t S_ERROR    = 4'd12;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    // AddressingControl value outside memory states (word access)
    localparam logic [2:0] ADDR_WORD = 3'b010;

    function automatic logic [2:0] imm_src_of(input logic [6:0] opc);
        case (opc)
            OPC_STORE:           return IMM_S;
            OPC_BRANCH:          return IMM_B;
            OPC_LUI, OPC_AUIPC:  return IMM_U;
            OPC_JAL:             return IMM_J;
            default:             return IMM_I;
        endcase
    endfunction

    function automatic logic opcode_known(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
            OPC_OPIMM, OPC_OP, OPC_LUI, OPC_AUIPC: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
// Control bus between the multi-cycle sequencer and the RV32I datapath.
//   master : controller side (receives Instr/Zero/mem_ready/halt_req,
//            drives all control strobes and status flags)
//   slave  : datapath / memory side (opposite directions)
// ----------------------------------------------------------------------------
interface multicycle_control_if;
    logic [31:0] Instr;
    logic        Zero;
    logic        mem_ready;
    logic        halt_req;

    logic        PCWrite;
    logic        IRWrite;
    logic [1:0]  PCSrc;
    logic        RegWrite;
    logic [3:0]  ALUControl;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic        MemWrite;
    logic [1:0]  ResultSrc;
    logic [2:0]  ImmSrc;
    logic [2:0]  AddressingControl;
    logic        instr_done;
    logic        halted;
    logic        error;
    logic        illegal;

    modport master (
        input  Instr, Zero, mem_ready, halt_req,
        output PCWrite, IRWrite, PCSrc, RegWrite, ALUControl, ALUSrcA, ALUSrcB,
               MemWrite, ResultSrc, ImmSrc, AddressingControl,
               instr_done, halted, error, illegal
    );

    modport slave (
        output Instr, Zero, mem_ready, halt_req,
        input  PCWrite, IRWrite, PCSrc, RegWrite, ALUControl, ALUSrcA, ALUSrcB,
               MemWrite, ResultSrc, ImmSrc, AddressingControl,
               instr_done, halted, error, illegal
    );
endinterface

// File: rtl/mctrl_alu_decoder.sv
// ----------------------------------------------------------------------------
// mctrl_alu_decoder
// Combinational {opcode, funct3, funct7[5]} -> ALUControl.
//   opcode    in  7  instruction opcode
//   funct3    in  3  instruction funct3
//   funct7b5  in  1  instruction bit 30
//   alu_control out 4 ALU operation (mctrl_pkg encoding)
// funct7[5] only matters for R-type ADD/SUB and for SRL/SRA (which also
// covers SRAI, whose immediate carries the same bit). Branches map to the
// compare op whose Zero result decides the branch; LUI passes operand B.
// Everything else (address calc, JALR, AUIPC) is an ADD.
// ----------------------------------------------------------------------------
module mctrl_alu_decoder
    import mctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        if (opcode == OPC_OP || opcode == OPC_OPIMM) begin
            case (funct3)
                3'b000:  alu_control = (opcode == OPC_OP && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_control = ALU_SLL;
                3'b010:  alu_control = ALU_SLT;
                3'b011:  alu_control = ALU_SLTU;
                3'b100:  alu_control = ALU_XOR;
                3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_control = ALU_OR;
                default: alu_control = ALU_AND;
            endcase
        end else if (opcode == OPC_BRANCH) begin
            case (funct3[2:1])
                2'b10:   alu_control = ALU_SLT;
                2'b11:   alu_control = ALU_SLTU;
                default: alu_control = ALU_SUB;
            endcase
        end else if (opcode == OPC_LUI) begin
            alu_control = ALU_PASSB;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle sequencer for the RV32I datapath. One instruction takes
// FETCH, DECODE and one or more execute states; memory accesses wait on
// mem_ready and trap to ERROR after MEM_TIMEOUT idle cycles.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous reset, active-high
//   bus  multicycle_control_if.master (Instr/Zero/mem_ready/halt_req in,
//        PCWrite/IRWrite/PCSrc/RegWrite/ALUControl/ALUSrcA/ALUSrcB/MemWrite/
//        ResultSrc/ImmSrc/AddressingControl/instr_done/halted/error/illegal out)
// Parameters:
//   MEM_TIMEOUT  cycles allowed in MEM_RD/MEM_WR without mem_ready (>=1)
//   TMO_W        wait counter width, must hold MEM_TIMEOUT
// Build option:
//   MCTRL_TRAP_EN  defined   -> unknown opcode traps to ERROR, illegal=1
//                  undefined -> unknown opcode retires as a NOP, illegal=0
// ----------------------------------------------------------------------------
module multicycle_control
    import mctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_if.master      bus
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [TMO_W-1:0] wait_cnt_reg, wait_cnt_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] alu_dec;
    logic       branch_taken;

    assign opcode = bus.Instr[6:0];
    assign funct3 = bus.Instr[14:12];

    mctrl_alu_decoder u_alu_dec (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (bus.Instr[30]),
        .alu_control (alu_dec)
    );

    // BEQ/BGE/BGEU take the branch on Zero, BNE/BLT/BLTU on !Zero;
    // funct3[0]^funct3[2] marks the inverted group.
    assign branch_taken = bus.Zero ^ (funct3[0] ^ funct3[2]);

    // ------------------------------------------------------------------
    // Next state and wait counter
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            S_FETCH:  state_next = bus.halt_req ? S_HALTED : S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_OP, OPC_OPIMM:   state_next = S_EXEC;
                    OPC_LOAD, OPC_STORE: state_next = S_MEM_ADDR;
                    OPC_BRANCH:          state_next = S_BRANCH;
                    OPC_JAL, OPC_JALR:   state_next = S_JUMP;
                    OPC_LUI, OPC_AUIPC:  state_next = S_UPPER;
`ifdef MCTRL_TRAP_EN
                    default:             state_next = S_ERROR;
`else
                    default:             state_next = S_NOP;
`endif
                endcase
            end
            // ALU and upper-immediate results are registered in the
            // datapath's ALUOut before writeback, hence the shared WB state.
            S_EXEC, S_UPPER:                  state_next = S_WB;
            S_WB, S_BRANCH, S_JUMP, S_NOP:    state_next = S_FETCH;
            S_MEM_ADDR: begin
                wait_cnt_next = '0;
                state_next    = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                // mem_ready wins over the timeout in the final wait cycle
                if (bus.mem_ready)
                    state_next = S_FETCH;
                else if (wait_cnt_reg == TMO_LAST)
                    state_next = S_ERROR;
                else
                    wait_cnt_next = wait_cnt_reg + 1'b1;
            end
            S_HALTED: if (!bus.halt_req) state_next = S_FETCH;
            S_ERROR:  state_next = S_ERROR;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Gated by rst so every strobe is low while reset is
    // held, even though the reset state is FETCH.
    // ------------------------------------------------------------------
    logic       pc_write, ir_write, reg_write, alu_src_a, alu_src_b, mem_write;
    logic [1:0] pc_src, result_src;
    logic [3:0] alu_control;
    logic [2:0] imm_src, addr_ctl;

    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        mem_write   = 1'b0;
        pc_src      = PC_PLUS4;
        result_src  = RES_ALU;
        alu_control = ALU_ADD;
        imm_src     = IMM_I;
        addr_ctl    = ADDR_WORD;
        if (!rst) begin
            case (state_reg)
                S_FETCH:  ir_write = !bus.halt_req;
                S_DECODE: imm_src  = imm_src_of(opcode);
                S_EXEC, S_UPPER, S_WB: begin
                    imm_src     = imm_src_of(opcode);
                    alu_control = alu_dec;
                    alu_src_a   = (opcode == OPC_AUIPC);
                    alu_src_b   = (opcode != OPC_OP);
                    if (state_reg == S_WB) begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                end
                S_MEM_ADDR, S_MEM_RD, S_MEM_WR: begin
                    imm_src   = imm_src_of(opcode);
                    alu_src_b = 1'b1;
                    addr_ctl  = funct3;
                    if (state_reg == S_MEM_RD && bus.mem_ready) begin
                        reg_write  = 1'b1;
                        result_src = RES_MEM;
                        pc_write   = 1'b1;
                    end
                    if (state_reg == S_MEM_WR) begin
                        mem_write = 1'b1;
                        pc_write  = bus.mem_ready;
                    end
                end
                S_BRANCH: begin
                    imm_src     = IMM_B;
                    alu_control = alu_dec;
                    pc_write    = 1'b1;
                    pc_src      = branch_taken ? PC_IMM : PC_PLUS4;
                end
                S_JUMP: begin
                    // Link value (PC+4) is still valid: PC only updates at this edge
                    imm_src    = imm_src_of(opcode);
                    reg_write  = 1'b1;
                    result_src = RES_PC4;
                    pc_write   = 1'b1;
                    if (opcode == OPC_JALR) begin
                        alu_src_b = 1'b1;
                        pc_src    = PC_ALU;
                    end else begin
                        pc_src    = PC_IMM;
                    end
                end
                S_NOP:   pc_write = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MCTRL_TRAP_EN
    logic illegal_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_reg <= 1'b0;
        else if (state_reg == S_DECODE && !opcode_known(opcode))
            illegal_reg <= 1'b1;
    end
    assign bus.illegal = illegal_reg;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.PCWrite           = pc_write;
    assign bus.IRWrite           = ir_write;
    assign bus.PCSrc             = pc_src;
    assign bus.RegWrite          = reg_write;
    assign bus.ALUControl        = alu_control;
    assign bus.ALUSrcA           = alu_src_a;
    assign bus.ALUSrcB           = alu_src_b;
    assign bus.MemWrite          = mem_write;
    assign bus.ResultSrc         = result_src;
    assign bus.ImmSrc            = imm_src;
    assign bus.AddressingControl = addr_ctl;
    assign bus.instr_done        = pc_write;
    assign bus.halted            = (state_reg == S_HALTED);
    assign bus.error             = (state_reg == S_ERROR);

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Scoreboard bench: each issued instruction pushes its expected retire-cycle
// controls and latency; a monitor pops and compares on every instr_done.
// Halt, timeout, illegal opcode and reset behaviour are checked inline.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control #(.MEM_TIMEOUT(16), .TMO_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0] pcsrc;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [3:0] alu;
        logic       memwrite;
        logic [2:0] addr;
        logic [7:0] lat;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int    cyc = 0;
    int    start_cyc = 0;
    exp_t  mon_e;
    string mon_nm;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                cyc++;
                if (bus.IRWrite) start_cyc = cyc;
                if (bus.instr_done) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_retire: got instr_done=1 expected no retire (t=%0t)", $time);
                    end else begin
                        mon_e  = exp_q.pop_front();
                        mon_nm = name_q.pop_front();
                        chk({mon_nm, "_pcsrc"},     32'(bus.PCSrc),             32'(mon_e.pcsrc));
                        chk({mon_nm, "_regwrite"},  32'(bus.RegWrite),          32'(mon_e.regwrite));
                        chk({mon_nm, "_resultsrc"}, 32'(bus.ResultSrc),         32'(mon_e.resultsrc));
                        chk({mon_nm, "_alu"},       32'(bus.ALUControl),        32'(mon_e.alu));
                        chk({mon_nm, "_memwrite"},  32'(bus.MemWrite),          32'(mon_e.memwrite));
                        chk({mon_nm, "_addrctl"},   32'(bus.AddressingControl), 32'(mon_e.addr));
                        chk({mon_nm, "_latency"},   32'(cyc - start_cyc + 1),   32'(mon_e.lat));
                        $display("retire %s latency=%0d pcsrc=%b alu=%b", mon_nm,
                                 cyc - start_cyc + 1, bus.PCSrc, bus.ALUControl);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next one.
    task automatic issue(input string nm, input logic [31:0] ins, input logic z,
                         input int ready_at, input int halt_at,
                         input logic [1:0] pcsrc, input logic rw, input logic [1:0] rs,
                         input logic [3:0] alu, input logic mw, input logic [2:0] addr,
                         input int lat);
        exp_q.push_back({pcsrc, rw, rs, alu, mw, addr, 8'(lat)});
        name_q.push_back(nm);
        bus.Instr = ins;
        bus.Zero  = z;
        for (int c = 0; c < lat; c++) begin
            bus.mem_ready = (c == ready_at);
            if (halt_at >= 0 && c >= halt_at) bus.halt_req = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, 32'({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.PCSrc,
                     bus.ResultSrc, bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                     bus.AddressingControl, bus.instr_done, bus.halted, bus.error, bus.illegal}),
            32'({17'b0, 3'b010, 4'b0}));
    endtask

    // Asserts rst immediately, checks outputs, releases at posedge+1.
    task automatic do_reset(input string nm);
        rst = 1'b1;
        #1;
        check_reset_outputs(nm);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    int mw_cnt;
    bit pcw_seen;

    initial begin
        bus.Instr     = 32'h0000_0013;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b0;
        bus.halt_req  = 1'b0;
        #2;
        check_reset_outputs("reset_state");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //     name         instr          Z  rdy hlt  pcsrc rw rs    alu      mw addr    lat
        issue("ADD",       32'h002081B3, 0, -1, -1, 2'b00, 1, 2'b00, 4'b0000, 0, 3'b010, 4);
        issue("SUB",       32'h402081B3, 0, -1, -1, 2'b00, 1, 2'b00, 4'b0001, 0, 3'b010, 4);
        issue("SRAI",      32'h40335293, 0, -1, -1, 2'b00, 1, 2'b00, 4'b0111, 0, 3'b010, 4);
        issue("ADDI_neg",  32'hFFF00093, 0, -1, -1, 2'b00, 1, 2'b00, 4'b0000, 0, 3'b010, 4);
        issue("LW_3wait",  32'h0000A283, 0,  6, -1, 2'b00, 1, 2'b01, 4'b0000, 0, 3'b010, 7);
        issue("LBU",       32'h0000C283, 0,  3, -1, 2'b00, 1, 2'b01, 4'b0000, 0, 3'b100, 4);
        issue("SW_2wait",  32'h0020A023, 0,  5, -1, 2'b00, 0, 2'b00, 4'b0000, 1, 3'b010, 6);
        issue("BNE_nz",    32'h00209463, 0, -1, -1, 2'b01, 0, 2'b00, 4'b0001, 0, 3'b010, 3);
        issue("BNE_z",     32'h00209463, 1, -1, -1, 2'b00, 0, 2'b00, 4'b0001, 0, 3'b010, 3);
        issue("BGE_z",     32'h0020D463, 1, -1, -1, 2'b01, 0, 2'b00, 4'b1000, 0, 3'b010, 3);
        issue("BLTU_nz",   32'h0020E463, 0, -1, -1, 2'b01, 0, 2'b00, 4'b1001, 0, 3'b010, 3);
        issue("JAL",       32'h010000EF, 0, -1, -1, 2'b01, 1, 2'b10, 4'b0000, 0, 3'b010, 3);
        issue("JALR",      32'h000080E7, 0, -1, -1, 2'b10, 1, 2'b10, 4'b0000, 0, 3'b010, 3);
        issue("LUI",       32'h123452B7, 0, -1, -1, 2'b00, 1, 2'b00, 4'b1010, 0, 3'b010, 4);
        issue("AUIPC",     32'h00001297, 0, -1, -1, 2'b00, 1, 2'b00, 4'b0000, 0, 3'b010, 4);

        // Halt requested during MEM_RD: load still retires, next FETCH halts
        issue("LW_halt",   32'h0000A283, 0,  4,  3, 2'b00, 1, 2'b01, 4'b0000, 0, 3'b010, 5);
        @(negedge clk);
        chk("halt_fetch_blocked", 32'(bus.IRWrite), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("halted_1", 32'(bus.halted), 32'd1);
        @(posedge clk); #1;
        bus.halt_req = 1'b0;
        @(negedge clk);
        chk("halted_2", 32'(bus.halted), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resume_fetch", 32'({bus.halted, bus.IRWrite}), 32'b01);
        issue("ADD_resume", 32'h002081B3, 0, -1, -1, 2'b00, 1, 2'b00, 4'b0000, 0, 3'b010, 4);

        // Unknown opcode 0x7F
`ifdef MCTRL_TRAP_EN
        bus.Instr = 32'h0000007F;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("trap_error",   32'(bus.error),   32'd1);
        chk("trap_illegal", 32'(bus.illegal), 32'd1);
        chk("trap_no_pcw",  32'(bus.PCWrite), 32'd0);
        do_reset("rst_after_trap");
`else
        issue("NOP_7F",    32'h0000007F, 0, -1, -1, 2'b00, 0, 2'b00, 4'b0000, 0, 3'b010, 3);
        chk("nop_illegal_low", 32'(bus.illegal), 32'd0);
`endif

        // Store with mem_ready never asserted -> timeout
        bus.Instr     = 32'h0020A023;
        bus.mem_ready = 1'b0;
        mw_cnt   = 0;
        pcw_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.MemWrite) mw_cnt++;
            if (bus.PCWrite)  pcw_seen = 1'b1;
            if (bus.error)    break;
        end
        chk("tmo_memwrite_cycles", 32'(mw_cnt),      32'd16);
        chk("tmo_error",           32'(bus.error),   32'd1);
        chk("tmo_no_pcwrite",      32'(pcw_seen),    32'd0);
        chk("tmo_illegal_low",     32'(bus.illegal), 32'd0);
        $display("timeout store: memwrite_cycles=%0d error=%b", mw_cnt, bus.error);
        @(posedge clk); #1;
        do_reset("rst_after_tmo");

        // Reset asserted in the middle of MEM_WR
        bus.Instr = 32'h0020A023;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        chk("abort_memwrite_pre", 32'(bus.MemWrite), 32'd1);
        do_reset("rst_mid_memwr");
        $display("reset mid-store: memwrite dropped with rst");

        issue("ADD_post_rst", 32'h002081B3, 0, -1, -1, 2'b00, 1, 2'b00, 4'b0000, 0, 3'b010, 4);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
